muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//   Iterative RV32M-style multiply/divide unit beside the core ALU, parametrised in operand width XLEN.
//   Each op takes many cycles, controlled by a start/busy/done handshake, so the core's multi-cycle
//   controller can stall in an execute state until done. It decodes funct3 exactly as RV32M (opcode 0x0C, funct7=1).
// PARAMETERS
//   XLEN       32  operand/result width in bits (>=8, even)
//   EARLY_OUT  1   1: divide-by-zero and signed-overflow divides finish 1 edge after accept; 0: full latency
// PORTS
//   clk     in   1     clock, rising edge
//   rstn    in   1     reset: asynchronous and active-low
//   start   in   1     request; accepted only when busy=0
//   funct3  in   3     op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   srca    in   XLEN  operand rs1 (multiplicand / dividend)
//   srcb    in   XLEN  operand rs2 (multiplier / divisor)
//   busy    out  1     operation in flight
//   done    out  1     one-cycle pulse; res valid from this cycle
//   res     out  XLEN  result; held until the next done
// BEHAVIOUR
//   Reset (rstn low, any time, asynchronous): state=IDLE, busy=0, done=0, res=0, all internal regs 0.
//     An op in flight is abandoned and does not produce a done.
//   FSM states: IDLE -> MUL|DIV -> FIX -> IDLE.
//   IDLE:
//     - On an edge with start=1, latch funct3, srca and srcb, and capture operand magnitudes and signs.
//     - Load the iteration counter with XLEN and set busy=1.
//     - Operands may change freely after the accepting edge (E0).
//   MUL: shift-add over magnitudes into a 2*XLEN product, one bit per edge.
//     - Signedness per op: MULH both signed; MULHSU srca signed, srcb unsigned; MUL and MULHU unsigned magnitudes.
//     - MUL's low half is sign-agnostic.
//   DIV: restoring divide over magnitudes, one quotient bit per edge.
//     - DIV/REM use signed operands; DIVU/REMU use unsigned operands.
//   FIX: one edge.
//     - Negate the product if the operand signs differ (signed ops).
//     - Negate the quotient if the signs differ; the remainder takes the sign of the dividend.
//     - Select res: MUL = low XLEN bits; MULH* = high XLEN bits; DIV* = quotient; REM* = remainder.
//     - Set done=1 and busy=0; return to IDLE.
//   Latency: done is high after edge E0+XLEN+1 (E33 at XLEN=32), for exactly one cycle.
//   Special cases, resolved at E0 and reported at E1 when EARLY_OUT=1 (otherwise at full latency, same values):
//     - srcb==0: DIV and DIVU give all ones; REM and REMU give srca.
//     - DIV with srca==MIN_NEG and srcb==-1: res = MIN_NEG. REM with the same operands: res = 0.
//   start while busy=1: ignored; no effect on the op in flight.
//   start in the done cycle: accepted (state is already IDLE). done falls and busy rises on that edge.
//   All arithmetic is modulo 2^XLEN; the internal product is 2*XLEN bits wide. No X on res at any time after reset.
// TESTING
//   1. MUL 7 * 0xFFFFFFFD -> res 0xFFFFFFEB; done high exactly after E33, busy high E0..E32.
//   2. MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF^2 -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
//   3. DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
//   4. DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, done at E1 (EARLY_OUT=1); also at E33 with EARLY_OUT=0.
//   5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
//   6. start pulsed mid-op -> ignored, original result returned.
//      rstn low at E10 -> busy=0, done=0, res=0 immediately; a following DIVU 9/3 returns 3.
//      Back-to-back start in the done cycle -> second op completes 33 edges later.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide with start/busy/done handshake
module muldiv_unit #(
    parameter int XLEN      = 32,
    parameter int EARLY_OUT = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] res
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        r_state;
    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_mcand;
    logic [2*XLEN-1:0] r_prod;
    logic [CW-1:0]     r_cnt;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_spec;
    logic [XLEN-1:0]   r_spec_res;
    logic              r_done;
    logic [XLEN-1:0]   r_res;

    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_b_zero;
    logic              w_ovf;
    logic              w_spec;
    logic [XLEN-1:0]   w_spec_res;
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_div_sh;
    logic [XLEN:0]     w_div_diff;
    logic [2*XLEN-1:0] w_div_next;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_q_raw;
    logic [XLEN-1:0]   w_r_raw;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_res;

    // operand decode at accept: signedness, magnitudes and the divide special cases
    always_comb begin
        w_a_signed = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3 == 3'b100) | (funct3 == 3'b110);
        w_b_signed = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
        w_a_neg    = w_a_signed & srca[XLEN-1];
        w_b_neg    = w_b_signed & srcb[XLEN-1];
        w_a_mag    = w_a_neg ? -srca : srca;
        w_b_mag    = w_b_neg ? -srcb : srcb;
        w_b_zero   = (srcb == '0);
        w_ovf      = funct3[2] & ~funct3[0] & (srca == MIN_NEG) & (&srcb);
        w_spec     = funct3[2] & (w_b_zero | w_ovf);
        w_spec_res = funct3[1] ? (w_b_zero ? srca : '0) : (w_b_zero ? '1 : MIN_NEG);
    end

    // one iteration step: shift-add for multiply, restoring subtract for divide
    always_comb begin
        w_mul_sum  = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
        w_mul_next = {w_mul_sum, r_prod[XLEN-1:1]};
        w_div_sh   = {r_prod[2*XLEN-1:XLEN], r_prod[XLEN-1]};
        w_div_diff = w_div_sh - {1'b0, r_mcand};
        w_div_next = w_div_diff[XLEN] ? {w_div_sh[XLEN-1:0], r_prod[XLEN-2:0], 1'b0}
                                      : {w_div_diff[XLEN-1:0], r_prod[XLEN-2:0], 1'b1};
    end

    // sign fix-up and result selection; special cases override the iterated value
    always_comb begin
        w_prod_fix = r_neg_q ? -r_prod : r_prod;
        w_q_raw    = r_prod[XLEN-1:0];
        w_r_raw    = r_prod[2*XLEN-1:XLEN];
        w_quo      = r_neg_q ? -w_q_raw : w_q_raw;
        w_rem      = r_neg_r ? -w_r_raw : w_r_raw;
        w_fix_res  = r_spec ? r_spec_res
                   : r_op[2] ? (r_op[1] ? w_rem : w_quo)
                   : (r_op[1:0] == 2'b00) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];
    end

    // control FSM and datapath registers: IDLE -> MUL|DIV -> FIX -> IDLE
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_mcand    <= '0;
            r_prod     <= '0;
            r_cnt      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_spec     <= 1'b0;
            r_spec_res <= '0;
            r_done     <= 1'b0;
            r_res      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_op       <= funct3;
                    r_mcand    <= funct3[2] ? w_b_mag : w_a_mag;
                    r_prod     <= {{XLEN{1'b0}}, (funct3[2] ? w_a_mag : w_b_mag)};
                    r_cnt      <= CW'(XLEN);
                    r_neg_q    <= w_a_neg ^ w_b_neg;
                    r_neg_r    <= w_a_neg;
                    r_spec     <= w_spec;
                    r_spec_res <= w_spec_res;
                    r_state    <= (w_spec && EARLY_OUT != 0) ? S_FIX : (funct3[2] ? S_DIV : S_MUL);
                end
                S_MUL, S_DIV: begin
                    r_prod  <= (r_state == S_DIV) ? w_div_next : w_mul_next;
                    r_cnt   <= r_cnt - CW'(1);
                    r_state <= (r_cnt == CW'(1)) ? S_FIX : r_state;
                end
                default: begin
                    r_res   <= w_fix_res;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign res  = r_res;
endmodule
